// File: rtl/sira_istatistik_birimi.sv
// Streaming rank-order unit: collects PENCERE samples into an ascending array by
// single-cycle insertion, then returns the min, median, max or a selected rank.
`timescale 1ns/1ps
module sira_istatistik_birimi #(
    parameter int unsigned VERI_BIT = 8,
    parameter int unsigned PENCERE  = 9,
    parameter int unsigned SIRA_BIT = $clog2(PENCERE)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                giris_gecerli_i,
    output logic                giris_hazir_o,
    input  logic [VERI_BIT-1:0] sayi_i,
    input  logic [1:0]          mod_i,
    input  logic [SIRA_BIT-1:0] sira_i,
    input  logic                temizle_i,
    output logic [VERI_BIT-1:0] sonuc_o,
    output logic                sonuc_gecerli_o,
    input  logic                sonuc_hazir_i,
    output logic [SIRA_BIT-1:0] sayac_o
);

    typedef enum logic [1:0] {
        TOPLA   = 2'd0,
        HESAPLA = 2'd1,
        SUN     = 2'd2
    } durum_t;

    localparam logic [SIRA_BIT-1:0] SON_SIRA = SIRA_BIT'(PENCERE - 1);
    localparam logic [SIRA_BIT-1:0] ORTA     = SIRA_BIT'((PENCERE - 1) / 2);

    durum_t              durum_q, durum_d;
    logic [SIRA_BIT-1:0] sayac_q, sayac_d;
    logic [SIRA_BIT-1:0] sira_q, sira_d;
    logic [VERI_BIT-1:0] sonuc_q, sonuc_d;
    logic [VERI_BIT-1:0] dizi_q [PENCERE];
    logic [VERI_BIT-1:0] dizi_d [PENCERE];
    logic [VERI_BIT-1:0] eklenmis [PENCERE];
    logic [PENCERE-1:0]  ust;
    logic [SIRA_BIT-1:0] yeni_sira;

    // ust[i]: slot i lies at or above the insertion point. Strict '>' keeps ties stable,
    // and slots beyond the count always count as above.
    always_comb begin
        ust = '0;
        for (int unsigned i = 0; i < PENCERE; i++) begin
            ust[i] = (SIRA_BIT'(i) >= sayac_q) || (dizi_q[i] > sayi_i);
        end
        eklenmis[0] = ust[0] ? sayi_i : dizi_q[0];
        for (int unsigned i = 1; i < PENCERE; i++) begin
            if (!ust[i]) begin
                eklenmis[i] = dizi_q[i];
            end else if (ust[i-1]) begin
                eklenmis[i] = dizi_q[i-1];
            end else begin
                eklenmis[i] = sayi_i;
            end
        end
    end

    always_comb begin
        yeni_sira = '0;
        case (mod_i)
            2'b00:   yeni_sira = '0;
            2'b01:   yeni_sira = ORTA;
            2'b10:   yeni_sira = SON_SIRA;
            default: yeni_sira = (32'(sira_i) >= PENCERE) ? SON_SIRA : sira_i;
        endcase
    end

    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        sira_d  = sira_q;
        sonuc_d = sonuc_q;
        dizi_d  = dizi_q;
        if (temizle_i) begin
            durum_d = TOPLA;
            sayac_d = '0;
        end else begin
            case (durum_q)
                TOPLA: begin
                    if (giris_gecerli_i) begin
                        dizi_d = eklenmis;
                        if (sayac_q == '0) begin
                            sira_d = yeni_sira;
                        end
                        if (sayac_q == SON_SIRA) begin
                            sayac_d = '0;
                            durum_d = HESAPLA;
                        end else begin
                            sayac_d = sayac_q + SIRA_BIT'(1);
                        end
                    end
                end
                HESAPLA: begin
                    sonuc_d = dizi_q[sira_q];
                    durum_d = SUN;
                end
                SUN: begin
                    if (sonuc_hazir_i) begin
                        durum_d = TOPLA;
                    end
                end
                default: durum_d = TOPLA;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q <= TOPLA;
            sayac_q <= '0;
            sira_q  <= '0;
            sonuc_q <= '0;
            for (int unsigned i = 0; i < PENCERE; i++) begin
                dizi_q[i] <= '0;
            end
        end else begin
            durum_q <= durum_d;
            sayac_q <= sayac_d;
            sira_q  <= sira_d;
            sonuc_q <= sonuc_d;
            dizi_q  <= dizi_d;
        end
    end

    assign giris_hazir_o   = (durum_q == TOPLA);
    assign sonuc_gecerli_o = (durum_q == SUN);
    assign sonuc_o         = sonuc_q;
    assign sayac_o         = sayac_q;

endmodule

// File: tb/tb_sira_istatistik_birimi.sv
// Directed bench for sira_istatistik_birimi: default 8-bit/9-sample instance plus a
// 10-bit/5-sample instance, all expectations hand-computed.
`timescale 1ns/1ps
module tb_sira_istatistik_birimi;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       gecerli, hazir_o, temizle, sonuc_gecerli, sonuc_hazir;
    logic [7:0] sayi, sonuc;
    logic [1:0] mod;
    logic [3:0] sira, sayac;

    logic       g2, h2, temizle2, sg2, sh2;
    logic [9:0] sayi2, sonuc2;
    logic [1:0] mod2;
    logic [2:0] sira2, sayac2;

    int kontrol_sayisi = 0;
    int hata_sayisi = 0;
    int cyc = 0;

    logic [7:0] akis [9];
    logic [9:0] akis2 [5];
    logic [7:0] veri5 [27];
    logic [7:0] bek5 [3];
    int         bas [3];
    int         idx, nres;
    logic       hp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sira_istatistik_birimi dut (
        .clk_i(clk), .rstn_i(rstn),
        .giris_gecerli_i(gecerli), .giris_hazir_o(hazir_o), .sayi_i(sayi),
        .mod_i(mod), .sira_i(sira), .temizle_i(temizle),
        .sonuc_o(sonuc), .sonuc_gecerli_o(sonuc_gecerli), .sonuc_hazir_i(sonuc_hazir),
        .sayac_o(sayac)
    );

    sira_istatistik_birimi #(.VERI_BIT(10), .PENCERE(5)) dut5 (
        .clk_i(clk), .rstn_i(rstn),
        .giris_gecerli_i(g2), .giris_hazir_o(h2), .sayi_i(sayi2),
        .mod_i(mod2), .sira_i(sira2), .temizle_i(temizle2),
        .sonuc_o(sonuc2), .sonuc_gecerli_o(sg2), .sonuc_hazir_i(sh2),
        .sayac_o(sayac2)
    );

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s gozlenen=%0d beklenen=%0d", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic adim();
        @(posedge clk);
        #1;
    endtask

    // mod/sira are inverted after the first sample to show they are latched only once
    task automatic pencere_yukle(input logic [1:0] m, input logic [3:0] s);
        for (int i = 0; i < 9; i++) begin
            mod     = (i == 0) ? m : ~m;
            sira    = (i == 0) ? s : ~s;
            gecerli = 1'b1;
            sayi    = akis[i];
            adim();
        end
        gecerli = 1'b0;
    endtask

    task automatic sonuc_bekle(input string etiket, input logic [7:0] beklenen);
        int t = 0;
        while (!sonuc_gecerli && t < 10) begin
            adim();
            t++;
        end
        kontrol({etiket, "_gecerli"}, sonuc_gecerli, 1);
        kontrol(etiket, sonuc, beklenen);
        sonuc_hazir = 1'b1;
        adim();
        sonuc_hazir = 1'b0;
        kontrol({etiket, "_hazir"}, hazir_o, 1);
    endtask

    task automatic pencere5(input string etiket, input logic [9:0] beklenen);
        int t = 0;
        mod2 = 2'b01;
        for (int i = 0; i < 5; i++) begin
            g2    = 1'b1;
            sayi2 = akis2[i];
            adim();
        end
        g2 = 1'b0;
        while (!sg2 && t < 10) begin
            adim();
            t++;
        end
        kontrol({etiket, "_gecerli"}, sg2, 1);
        kontrol(etiket, sonuc2, beklenen);
        sh2 = 1'b1;
        adim();
        sh2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL zaman_asimi gozlenen=calisiyor beklenen=bitti");
        $fatal(1, "zaman asimi");
    end

    initial begin
        gecerli = 0; sayi = 0; mod = 0; sira = 0; temizle = 0; sonuc_hazir = 0;
        g2 = 0; sayi2 = 0; mod2 = 0; sira2 = 0; temizle2 = 0; sh2 = 0;
        #2 rstn = 1'b0;
        #1;
        kontrol("reset_sonuc", sonuc, 0);
        kontrol("reset_gecerli", sonuc_gecerli, 0);
        kontrol("reset_hazir", hazir_o, 1);
        kontrol("reset_sayac", sayac, 0);
        kontrol("reset5_hazir", h2, 1);
        adim();
        adim();
        rstn = 1'b1;

        // median of 7,7,1,1,1,2,2,9,8 -> sorted 1,1,1,2,2,7,7,8,9
        akis = '{8'd7, 8'd7, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd8};
        pencere_yukle(2'b01, 4'd0);
        kontrol("gecikme_1_gecerli", sonuc_gecerli, 0);
        kontrol("gecikme_1_hazir", hazir_o, 0);
        adim();
        kontrol("gecikme_2_gecerli", sonuc_gecerli, 1);
        kontrol("medyan", sonuc, 2);
        kontrol("medyan_sayac", sayac, 0);

        // backpressure: offered samples must be ignored
        gecerli = 1'b1;
        sayi    = 8'd55;
        repeat (5) begin
            adim();
            kontrol("bekle_sonuc", sonuc, 2);
            kontrol("bekle_hazir", hazir_o, 0);
            kontrol("bekle_sayac", sayac, 0);
        end
        gecerli     = 1'b0;
        sonuc_hazir = 1'b1;
        adim();
        sonuc_hazir = 1'b0;
        kontrol("tuketim_hazir", hazir_o, 1);
        kontrol("tuketim_gecerli", sonuc_gecerli, 0);
        kontrol("tuketim_sayac", sayac, 0);

        pencere_yukle(2'b00, 4'd0);
        sonuc_bekle("min", 8'd1);
        pencere_yukle(2'b10, 4'd0);
        sonuc_bekle("max", 8'd9);
        pencere_yukle(2'b11, 4'd6);
        sonuc_bekle("sira6", 8'd7);
        pencere_yukle(2'b11, 4'd15);
        sonuc_bekle("sira_kirp", 8'd9);

        // abort after 4 samples together with a valid sample
        gecerli = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sayi = akis[i];
            adim();
        end
        kontrol("iptal_once_sayac", sayac, 4);
        temizle = 1'b1;
        sayi    = 8'd3;
        adim();
        temizle = 1'b0;
        gecerli = 1'b0;
        kontrol("iptal_sayac", sayac, 0);
        kontrol("iptal_hazir", hazir_o, 1);
        akis = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        pencere_yukle(2'b01, 4'd0);
        sonuc_bekle("iptal_medyan", 8'd4);

        // back-to-back windows; medians 2, 4, 5
        veri5 = '{8'd7, 8'd7, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd8,
                  8'd8, 8'd0, 8'd7, 8'd1, 8'd6, 8'd2, 8'd5, 8'd3, 8'd4,
                  8'd5, 8'd5, 8'd5, 8'd3, 8'd3, 8'd200, 8'd200, 8'd200, 8'd100};
        bek5 = '{8'd2, 8'd4, 8'd5};
        bas  = '{0, 0, 0};
        sonuc_hazir = 1'b1;
        idx  = 0;
        nres = 0;
        for (int c = 0; c < 80 && nres < 3; c++) begin
            hp = hazir_o;
            if (idx < 27) begin
                gecerli = 1'b1;
                sayi    = veri5[idx];
                mod     = (idx % 9 == 0) ? 2'b01 : ((c % 2 == 1) ? 2'b10 : 2'b00);
            end else begin
                gecerli = 1'b0;
            end
            adim();
            if (hp && idx < 27) begin
                if (idx % 9 == 0) bas[idx / 9] = cyc;
                idx++;
            end
            if (sonuc_gecerli) begin
                kontrol("ardisik_medyan", sonuc, bek5[nres]);
                nres++;
            end
        end
        gecerli = 1'b0;
        adim();
        sonuc_hazir = 1'b0;
        kontrol("ardisik_adet", nres, 3);
        kontrol("ardisik_aralik1", bas[1] - bas[0], 11);
        kontrol("ardisik_aralik2", bas[2] - bas[1], 11);

        // async reset in HESAPLA
        akis = '{8'd7, 8'd7, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd8};
        pencere_yukle(2'b01, 4'd0);
        #2 rstn = 1'b0;
        #1;
        kontrol("rst_hes_sonuc", sonuc, 0);
        kontrol("rst_hes_gecerli", sonuc_gecerli, 0);
        kontrol("rst_hes_hazir", hazir_o, 1);
        kontrol("rst_hes_sayac", sayac, 0);
        #1 rstn = 1'b1;

        // async reset in SUN
        pencere_yukle(2'b01, 4'd0);
        adim();
        kontrol("sun_gecerli", sonuc_gecerli, 1);
        kontrol("sun_sonuc", sonuc, 2);
        #2 rstn = 1'b0;
        #1;
        kontrol("rst_sun_sonuc", sonuc, 0);
        kontrol("rst_sun_gecerli", sonuc_gecerli, 0);
        kontrol("rst_sun_hazir", hazir_o, 1);
        #1 rstn = 1'b1;
        akis = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        pencere_yukle(2'b01, 4'd0);
        sonuc_bekle("rst_sonrasi_medyan", 8'd4);

        // 10-bit, 5-sample instance
        akis2 = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023};
        pencere5("p5_esit", 10'd1023);
        akis2 = '{10'd5, 10'd1023, 10'd0, 10'd700, 10'd700};
        pencere5("p5_medyan", 10'd700);

        $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
